// File: rtl/xclk_pkg.sv
// xclk_pkg: shared constants and the elaboration-time depth check for xclk_sync_filter.
package xclk_pkg;
    localparam int XCLK_MIN_STAGES = 2;
    localparam int XCLK_NCH        = 10;
    localparam int XCLK_STAGES     = 3;
    localparam int XCLK_FILT_W     = 4;
    function automatic bit stages_ok(input int stages);
        return stages >= XCLK_MIN_STAGES;
    endfunction
endpackage

// File: rtl/xclk_sync_filter_if.sv
// xclk_sync_filter_if: control, async input and synchronised/filtered output bundle.
interface xclk_sync_filter_if
    import xclk_pkg::*;
#(
    parameter int NCH    = XCLK_NCH,
    parameter int FILT_W = XCLK_FILT_W
) ();
    logic              en_i;
    logic [FILT_W-1:0] filt_len_i;
    logic [NCH-1:0]    async_i;
    logic [NCH-1:0]    sync_o;
    logic [NCH-1:0]    filt_o;
    logic [NCH-1:0]    rise_o;
    logic [NCH-1:0]    fall_o;
    logic              chg_o;
    modport master (output en_i, filt_len_i, async_i, input sync_o, filt_o, rise_o, fall_o, chg_o);
    modport slave  (input en_i, filt_len_i, async_i, output sync_o, filt_o, rise_o, fall_o, chg_o);
endinterface

// File: rtl/xclk_filter_ch.sv
// xclk_filter_ch: one channel's stability filter; edge pulses only when XCLK_SYNC_EDGE_EN is defined.
module xclk_filter_ch #(
    parameter int   FILT_W  = 4,
    parameter logic RST_VAL = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [FILT_W-1:0] filt_len_i,
    input  logic              sync_i,
    output logic              filt_o,
    output logic              rise_o,
    output logic              fall_o
);
    logic [FILT_W-1:0] cnt;
    logic              diff;
    logic              upd;
    assign diff = sync_i != filt_o;
    // >= rather than == so lowering the threshold mid-count still accepts promptly
    assign upd  = diff && (!en_i || cnt >= filt_len_i);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            filt_o <= RST_VAL;
            cnt    <= '0;
        end else begin
            if (upd) filt_o <= sync_i;
            cnt <= (en_i && diff && !upd) ? cnt + 1'b1 : '0;
        end
    end
`ifdef XCLK_SYNC_EDGE_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else begin
            rise_o <= upd && sync_i;
            fall_o <= upd && !sync_i;
        end
    end
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif
endmodule

// File: rtl/xclk_sync_filter.sv
// xclk_sync_filter: NCH-channel flop-chain synchroniser plus per-channel glitch filter.
// Edge outputs (rise/fall/chg) are generated only when XCLK_SYNC_EDGE_EN is defined.
module xclk_sync_filter
    import xclk_pkg::*;
#(
    parameter int   NCH     = XCLK_NCH,
    parameter int   STAGES  = XCLK_STAGES,
    parameter int   FILT_W  = XCLK_FILT_W,
    parameter logic RST_VAL = 1'b0
) (
    input logic               clk_i,
    input logic               rst_i,
    xclk_sync_filter_if.slave bus
);
    if (!stages_ok(STAGES)) begin : g_bad_stages
        $error("xclk_sync_filter: STAGES below XCLK_MIN_STAGES");
    end
    logic [NCH-1:0] stage [STAGES];
    // pure flop chain, nothing combinational between stages
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < STAGES; k++) stage[k] <= {NCH{RST_VAL}};
        end else begin
            stage[0] <= bus.async_i;
            for (int k = 1; k < STAGES; k++) stage[k] <= stage[k-1];
        end
    end
    assign bus.sync_o = stage[STAGES-1];
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        xclk_filter_ch #(.FILT_W(FILT_W), .RST_VAL(RST_VAL)) u_ch (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .en_i       (bus.en_i),
            .filt_len_i (bus.filt_len_i),
            .sync_i     (stage[STAGES-1][i]),
            .filt_o     (bus.filt_o[i]),
            .rise_o     (bus.rise_o[i]),
            .fall_o     (bus.fall_o[i])
        );
    end
    assign bus.chg_o = |(bus.rise_o | bus.fall_o);
endmodule

// File: doc/xclk_sync_filter.md
Name: xclk_sync_filter

Overview:
Parametrised multi-channel input synchroniser with a per-channel glitch filter, bringing asynchronous level signals into the clk_i domain. Each channel runs a STAGES-deep flop chain, then a programmable stability filter; optional edge-pulse outputs feed event logic downstream. Placed at the boundary between pad/foreign-domain status lines and core control logic.

Parameters:
NCH, 10, number of independent channels
STAGES, 3, synchroniser depth (>= XCLK_MIN_STAGES = 2)
FILT_W, 4, width of the filter counter and filt_len_i
RST_VAL, 1'b0, reset value of every chain flop and filt_o bit (replicated per channel)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
en_i  in  1  filter enable; 0 = bypass
filt_len_i  in  FILT_W  stability threshold; must be quasi-static
async_i  in  NCH  asynchronous inputs
sync_o  out  NCH  raw synchronised value (last chain stage)
filt_o  out  NCH  filtered, stable value
rise_o  out  NCH  one-cycle pulse on filt_o 0->1
fall_o  out  NCH  one-cycle pulse on filt_o 1->0
chg_o  out  1  one-cycle pulse: any rise_o/fall_o bit set

Behaviour:
- Reset (async, immediate): chain flops and filt_o = RST_VAL; counters 0; rise_o/fall_o/chg_o = 0.
- Chain: stage[0] <= async_i, stage[k] <= stage[k-1]; sync_o = stage[STAGES-1]; latency STAGES clk_i edges; no logic between stages.
- Filter per channel, en_i=1:
  - sync_o[i] == filt_o[i]: cnt <= 0.
  - differs and cnt >= filt_len_i: filt_o[i] <= sync_o[i], cnt <= 0.
  - differs otherwise: cnt <= cnt + 1.
  - New value accepted after filt_len_i+1 consecutive differing cycles; filt_len_i=0 -> 1-cycle lag.
  - Any return to agreement before threshold clears cnt (glitch rejected).
  - >= compare: lowering filt_len_i mid-count below cnt updates next cycle; cnt never wraps (max reaches 2^FILT_W-1 only when threshold is that value).
- en_i=0: filt_o <= sync_o every cycle, cnt <= 0. Toggling en_i mid-count discards the count.
- Edges: rise_o/fall_o/chg_o registered in the same cycle as the filt_o update (asserted exactly while the new filt_o value first appears), for one cycle. Multiple channels may pulse simultaneously; chg_o is their OR. Bypass-mode changes also pulse.
- No spurious edge on reset release (filt_o and its compare state both start at RST_VAL).
- Channels fully independent; no cross-channel coherency guaranteed (not for multi-bit buses/counters).

Optional Feature:
XCLK_SYNC_EDGE_EN. Defined: rise_o, fall_o, chg_o generated as above. Undefined: those outputs tied to 0, no edge flops instantiated; sync_o/filt_o behaviour unchanged.

Decomposition:
- Package xclk_pkg: XCLK_MIN_STAGES = 2, default NCH/STAGES/FILT_W constants; static elaboration check STAGES >= XCLK_MIN_STAGES.
- Sub-module xclk_filter_ch: one channel's counter, filt_o flop and edge flops; top generates NCH instances plus the chain array and chg_o OR.

Test Plan:
1. rst_i=1, async_i=10'h3FF -> all outputs 0 during reset; after release sync_o=10'h3FF exactly 3 edges later; en_i=1, filt_len_i=0 -> filt_o=10'h3FF 1 edge after that, rise_o=10'h3FF and chg_o=1 for that one cycle.
2. filt_len_i=2, async_i[0] 0->1 at edge 0 -> sync_o[0]=1 after edge 3, filt_o[0]=1 and rise_o[0]=1 after edge 6, rise_o[0]=0 after edge 7.
3. filt_len_i=3, 3-cycle high pulse on async_i[5] -> sync_o[5] shows it, filt_o[5] stays 0, no rise_o; 4-cycle pulse -> filt_o[5] high 4 cycles, rise_o[5] then fall_o[5] pulses.
4. en_i=0, toggle async_i[2] -> filt_o[2] follows sync_o[2] with 1-cycle lag, rise/fall pulses; en_i 1->0->1 during an 8-cycle differing run with filt_len_i=15 -> count restarts.
5. filt_len_i=15, channel differing for 8 cycles, then filt_len_i=4 -> filt_o updates on the next edge.
6. rst_i asserted mid-count with async_i=0 after release -> outputs cleared immediately, no pulse after release; build without XCLK_SYNC_EDGE_EN -> rise_o/fall_o/chg_o constant 0 across tests 1-5.
